// File: rtl/result_tx_fsm.sv
// Serializes one captured 2*DATA_W result as high word then low word; with
// RESULT_TX_STATUS_EN a third {op_code, flags, 0} status word follows.
module result_tx_fsm #(
   parameter int DATA_W = 32,
   parameter int CODE_W = 8,
   parameter int FLAG_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_i,
   input  logic                result_valid_i,
   output logic                result_ready_o,
   input  logic [2*DATA_W-1:0] result_i,
   input  logic [CODE_W-1:0]   op_code_i,
   input  logic [FLAG_W-1:0]   flags_i,
   output logic [DATA_W-1:0]   wr_data_o,
   output logic                wr_data_valid_o,
   input  logic                wr_data_ready_i,
   output logic                tx_done_o,
   output logic [CNT_W-1:0]    sent_count_o
);

`ifdef RESULT_TX_STATUS_EN
   typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO, SEND_STAT} state_t;
   localparam state_t LAST_ST = SEND_STAT;
   localparam int     PAD_W   = DATA_W - CODE_W - FLAG_W;
   logic [CODE_W-1:0] cap_op_q;
   logic [FLAG_W-1:0] cap_flags_q;
`else
   typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;
   localparam state_t LAST_ST = SEND_LO;
   logic unused_status_in;
   assign unused_status_in = ^{op_code_i, flags_i};
`endif

   state_t              state_q;
   logic [DATA_W-1:0]   cap_lo_q;
   logic [DATA_W-1:0]   wr_data_q;
   logic                wr_data_valid_q;
   logic                result_ready_q;
   logic [CNT_W-1:0]    sent_count_q;

   assign result_ready_o  = result_ready_q;
   assign wr_data_o       = wr_data_q;
   assign wr_data_valid_o = wr_data_valid_q;
   assign sent_count_o    = sent_count_q;
   // Done is qualified by the live ready so it coincides with the accepting cycle.
   assign tx_done_o       = wr_data_valid_q & wr_data_ready_i & (state_q == LAST_ST);

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q         <= IDLE;
         cap_lo_q        <= '0;
         wr_data_q       <= '0;
         wr_data_valid_q <= 1'b0;
         result_ready_q  <= 1'b1;
         sent_count_q    <= '0;
`ifdef RESULT_TX_STATUS_EN
         cap_op_q        <= '0;
         cap_flags_q     <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (result_valid_i) begin
                  // High word goes straight to the output register; only the low half is kept.
                  cap_lo_q        <= result_i[DATA_W-1:0];
                  wr_data_q       <= result_i[2*DATA_W-1:DATA_W];
                  wr_data_valid_q <= 1'b1;
                  result_ready_q  <= 1'b0;
                  state_q         <= SEND_HI;
`ifdef RESULT_TX_STATUS_EN
                  cap_op_q        <= op_code_i;
                  cap_flags_q     <= flags_i;
`endif
               end
            end
            SEND_HI: begin
               if (wr_data_ready_i) begin
                  wr_data_q <= cap_lo_q;
                  state_q   <= SEND_LO;
               end
            end
            SEND_LO: begin
               if (wr_data_ready_i) begin
`ifdef RESULT_TX_STATUS_EN
                  wr_data_q <= {cap_op_q, cap_flags_q, {PAD_W{1'b0}}};
                  state_q   <= SEND_STAT;
`else
                  wr_data_q       <= '0;
                  wr_data_valid_q <= 1'b0;
                  result_ready_q  <= 1'b1;
                  sent_count_q    <= sent_count_q + 1'b1;
                  state_q         <= IDLE;
`endif
               end
            end
`ifdef RESULT_TX_STATUS_EN
            SEND_STAT: begin
               if (wr_data_ready_i) begin
                  wr_data_q       <= '0;
                  wr_data_valid_q <= 1'b0;
                  result_ready_q  <= 1'b1;
                  sent_count_q    <= sent_count_q + 1'b1;
                  state_q         <= IDLE;
               end
            end
`endif
            default: begin
               wr_data_valid_q <= 1'b0;
               result_ready_q  <= 1'b1;
               state_q         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_tx_fsm.sv
// Directed bench for result_tx_fsm: vector table plus reset, back-to-back and wrap sequences.
module tb_result_tx_fsm;

`ifdef RESULT_TX_STATUS_EN
   localparam int NW = 3;
`else
   localparam int NW = 2;
`endif
   localparam logic        LO_DONE = (NW == 2);
   localparam logic [31:0] STAT    = 32'h2A90_0000;
   localparam logic [63:0] R1 = 64'hDEADBEEF_01234567;
   localparam logic [63:0] R2 = 64'h13579BDF_2468ACE0;
   localparam logic [63:0] R3 = 64'hCAFEF00D_5A5A0FF0;
   localparam logic [63:0] JK = 64'hAAAAAAAA_55555555;

   logic        clk = 1'b0;
   logic        rst_i, result_valid_i, wr_data_ready_i;
   logic [63:0] result_i;
   logic [7:0]  op_code_i = 8'h2A;
   logic [3:0]  flags_i = 4'b1001;
   logic        result_ready_o, wr_data_valid_o, tx_done_o;
   logic [31:0] wr_data_o;
   logic [15:0] sent_count_o;
   logic        w_ready_o, w_valid_o, w_done_o;
   logic [31:0] w_data_o;
   logic [1:0]  w_count_o;

   always #5 clk = ~clk;

   result_tx_fsm dut (
      .clk(clk), .rst_i(rst_i), .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
      .result_i(result_i), .op_code_i(op_code_i), .flags_i(flags_i), .wr_data_o(wr_data_o),
      .wr_data_valid_o(wr_data_valid_o), .wr_data_ready_i(wr_data_ready_i),
      .tx_done_o(tx_done_o), .sent_count_o(sent_count_o));

   result_tx_fsm #(.CNT_W(2)) dut_w (
      .clk(clk), .rst_i(rst_i), .result_valid_i(result_valid_i), .result_ready_o(w_ready_o),
      .result_i(result_i), .op_code_i(op_code_i), .flags_i(flags_i), .wr_data_o(w_data_o),
      .wr_data_valid_o(w_valid_o), .wr_data_ready_i(wr_data_ready_i),
      .tx_done_o(w_done_o), .sent_count_o(w_count_o));

   typedef struct {
      logic        rst;
      logic        vld;
      logic [63:0] res;
      logic        rdy;
      logic        e_rrdy;
      logic        e_vld;
      logic [31:0] e_dat;
      logic        e_done;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tv[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [63:0] d, input logic rd);
      rst_i = r; result_valid_i = v; result_i = d; wr_data_ready_i = rd;
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] wexp(input logic [63:0] r, input int j);
      if (j == 0) return r[63:32];
      if (j == 1) return r[31:0];
      return STAT;
   endfunction

   logic [63:0] bb [4];

   initial begin
      bb[0] = 64'h11111111_22222222; bb[1] = 64'h33333333_44444444;
      bb[2] = 64'h55555555_66666666; bb[3] = 64'h77777777_88888888;

      // single result, ready always high
      tv.push_back('{1'b0, 1'b1, R1,    1'b1, 1'b1, 1'b0, 32'h0,        1'b0,    16'd0});
      tv.push_back('{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0,    16'd0});
      tv.push_back('{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 32'h01234567, LO_DONE, 16'd0});
`ifdef RESULT_TX_STATUS_EN
      tv.push_back('{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, STAT,         1'b1,    16'd0});
`endif
      // backpressure on the high word, stray valid and changing data while busy
      tv.push_back('{1'b0, 1'b1, R1,    1'b0, 1'b1, 1'b0, 32'h0,        1'b0,    16'd1});
      tv.push_back('{1'b0, 1'b1, JK,    1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0,    16'd1});
      tv.push_back('{1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0,    16'd1});
      tv.push_back('{1'b0, 1'b1, JK,    1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0,    16'd1});
      tv.push_back('{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0,    16'd1});
      tv.push_back('{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 32'h01234567, 1'b0,    16'd1});
      tv.push_back('{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 32'h01234567, LO_DONE, 16'd1});
`ifdef RESULT_TX_STATUS_EN
      tv.push_back('{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, STAT,         1'b0,    16'd1});
      tv.push_back('{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, STAT,         1'b1,    16'd1});
`endif
      tv.push_back('{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0,    16'd2});

      // reset for two cycles
      drive(1'b1, 1'b0, 64'h0, 1'b1);
      edge_wait();
      edge_wait();
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      #4;
      chk("rst_ready", {63'h0, result_ready_o}, 64'h1);
      chk("rst_valid", {63'h0, wr_data_valid_o}, 64'h0);
      chk("rst_data", {32'h0, wr_data_o}, 64'h0);
      chk("rst_done", {63'h0, tx_done_o}, 64'h0);
      chk("rst_count", {48'h0, sent_count_o}, 64'h0);
      edge_wait();

      foreach (tv[i]) begin
         drive(tv[i].rst, tv[i].vld, tv[i].res, tv[i].rdy);
         #4;
         chk($sformatf("v%0d_rready", i), {63'h0, result_ready_o}, {63'h0, tv[i].e_rrdy});
         chk($sformatf("v%0d_valid", i), {63'h0, wr_data_valid_o}, {63'h0, tv[i].e_vld});
         chk($sformatf("v%0d_data", i), {32'h0, wr_data_o}, {32'h0, tv[i].e_dat});
         chk($sformatf("v%0d_done", i), {63'h0, tx_done_o}, {63'h0, tv[i].e_done});
         chk($sformatf("v%0d_count", i), {48'h0, sent_count_o}, {48'h0, tv[i].e_cnt});
         edge_wait();
      end

      // reset while the low word is on the bus
      drive(1'b0, 1'b1, R2, 1'b1);
      edge_wait();
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      #4 chk("mid_hi", {32'h0, wr_data_o}, {32'h0, R2[63:32]});
      edge_wait();
      drive(1'b1, 1'b0, 64'h0, 1'b0);
      #4 chk("mid_lo", {32'h0, wr_data_o}, {32'h0, R2[31:0]});
      edge_wait();
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      #4;
      chk("mid_rst_valid", {63'h0, wr_data_valid_o}, 64'h0);
      chk("mid_rst_count", {48'h0, sent_count_o}, 64'h0);
      chk("mid_rst_ready", {63'h0, result_ready_o}, 64'h1);
      chk("mid_rst_wcount", {62'h0, w_count_o}, 64'h0);
      edge_wait();
      drive(1'b0, 1'b1, R3, 1'b1);
      edge_wait();
      for (int j = 0; j < NW; j++) begin
         drive(1'b0, 1'b0, 64'h0, 1'b1);
         #4;
         chk($sformatf("post_rst_w%0d", j), {32'h0, wr_data_o}, {32'h0, wexp(R3, j)});
         chk($sformatf("post_rst_done%0d", j), {63'h0, tx_done_o}, {63'h0, (j == NW-1)});
         edge_wait();
      end
      #4 chk("post_rst_count", {48'h0, sent_count_o}, 64'h1);

      // back-to-back with valid held; narrow instance checks the counter wrap
      drive(1'b1, 1'b0, 64'h0, 1'b1);
      edge_wait();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1, bb[k], 1'b1);
         #4;
         chk($sformatf("b2b_ready%0d", k), {63'h0, result_ready_o}, 64'h1);
         chk($sformatf("b2b_wcount%0d", k), {62'h0, w_count_o}, 64'(k));
         edge_wait();
         for (int j = 0; j < NW; j++) begin
            drive(1'b0, (k < 3), (k < 3) ? bb[k+1] : 64'h0, 1'b1);
            #4;
            chk($sformatf("b2b_busy%0d_%0d", k, j), {63'h0, result_ready_o}, 64'h0);
            chk($sformatf("b2b_w%0d_%0d", k, j), {31'h0, wr_data_valid_o, wr_data_o},
                {31'h0, 1'b1, wexp(bb[k], j)});
            chk($sformatf("b2b_done%0d_%0d", k, j), {63'h0, tx_done_o}, {63'h0, (j == NW-1)});
            edge_wait();
         end
      end
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      #4;
      chk("b2b_count", {48'h0, sent_count_o}, 64'd4);
      chk("wrap_count", {62'h0, w_count_o}, 64'd0);
      chk("b2b_idle_valid", {63'h0, wr_data_valid_o}, 64'h0);
      edge_wait();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
